// File: rtl/rtc_txn_arbiter_if.sv
// Bundle between the RTC requesters, the arbiter and the RTC transaction engine.
// The arbiter takes the slave view; the requester/engine side takes the master view.
interface rtc_txn_arbiter_if;
    logic [2:0]  req;
    logic [23:0] req_addr;
    logic [23:0] req_wdata;
    logic [2:0]  req_wr;
    logic [2:0]  grant;
    logic [2:0]  done_pulse;
    logic        err_pulse;
    logic [7:0]  rd_data;
    logic        rtc_en;
    logic        rtc_w_r;
    logic [7:0]  rtc_addr;
    logic [7:0]  rtc_wdata;
    logic        rtc_done;
    logic [7:0]  rtc_rdata;

    modport slave (
        input  req, req_addr, req_wdata, req_wr, rtc_done, rtc_rdata,
        output grant, done_pulse, err_pulse, rd_data,
        output rtc_en, rtc_w_r, rtc_addr, rtc_wdata
    );

    modport master (
        output req, req_addr, req_wdata, req_wr, rtc_done, rtc_rdata,
        input  grant, done_pulse, err_pulse, rd_data,
        input  rtc_en, rtc_w_r, rtc_addr, rtc_wdata
    );
endinterface

// File: rtl/rtc_txn_arbiter.sv
// Three-requester arbiter in front of a single RTC transaction engine.
// Requester 0 has absolute priority; requesters 1 and 2 alternate. A timeout aborts hung transactions.
module rtc_txn_arbiter #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic              clk,
    input  logic              reset_count,
    rtc_txn_arbiter_if.slave  io_bus
);
    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_idx;
    logic [1:0]  r_rr;
    logic [15:0] r_cnt;
    logic [7:0]  r_addr;
    logic [7:0]  r_wdata;
    logic        r_wr;
    logic        r_err;
    logic [7:0]  r_rd_data;

    logic [1:0]  w_win_idx;
    logic [7:0]  w_sel_addr;
    logic [7:0]  w_sel_wdata;
    logic        w_sel_wr;
    logic        w_any_req;
    logic        w_timeout;
    logic [2:0]  w_onehot;
    logic [7:0]  w_addr_arr  [3];
    logic [7:0]  w_wdata_arr [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = io_bus.req_addr[8*gi +: 8];
            assign w_wdata_arr[gi] = io_bus.req_wdata[8*gi +: 8];
        end
    endgenerate

    assign w_any_req = |io_bus.req;
    assign w_timeout = (r_cnt == TIMEOUT_CYC - 16'd1);
    assign w_onehot  = 3'b001 << r_idx;

    // r_rr holds the index (1 or 2) that wins when both round-robin requesters ask
    always_comb begin
        w_win_idx = 2'd0;
        if (io_bus.req[0]) begin
            w_win_idx = 2'd0;
        end else if (io_bus.req[1] && io_bus.req[2]) begin
            w_win_idx = r_rr;
        end else if (io_bus.req[1]) begin
            w_win_idx = 2'd1;
        end else if (io_bus.req[2]) begin
            w_win_idx = 2'd2;
        end
    end

    always_comb begin
        w_sel_addr  = w_addr_arr[0];
        w_sel_wdata = w_wdata_arr[0];
        w_sel_wr    = io_bus.req_wr[0];
        case (w_win_idx)
            2'd1: begin
                w_sel_addr  = w_addr_arr[1];
                w_sel_wdata = w_wdata_arr[1];
                w_sel_wr    = io_bus.req_wr[1];
            end
            2'd2: begin
                w_sel_addr  = w_addr_arr[2];
                w_sel_wdata = w_wdata_arr[2];
                w_sel_wr    = io_bus.req_wr[2];
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_next = BUSY;
            BUSY:    if (io_bus.rtc_done || w_timeout) w_state_next = GAP;
            GAP:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) r_state <= IDLE;
        else             r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) begin
            r_idx     <= 2'd0;
            r_rr      <= 2'd1;
            r_cnt     <= 16'd0;
            r_addr    <= 8'h00;
            r_wdata   <= 8'h00;
            r_wr      <= 1'b0;
            r_err     <= 1'b0;
            r_rd_data <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_idx   <= w_win_idx;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_wr    <= w_sel_wr;
                        r_cnt   <= 16'd0;
                        r_err   <= 1'b0;
                        if (w_win_idx == 2'd1) r_rr <= 2'd2;
                        if (w_win_idx == 2'd2) r_rr <= 2'd1;
                    end
                end
                // completion beats a coincident timeout
                BUSY: begin
                    if (io_bus.rtc_done) begin
                        if (!r_wr) r_rd_data <= io_bus.rtc_rdata;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.grant      = (r_state == BUSY) ? w_onehot : 3'b000;
    assign io_bus.done_pulse = (r_state == GAP)  ? w_onehot : 3'b000;
    assign io_bus.err_pulse  = (r_state == GAP) && r_err;
    assign io_bus.rtc_en     = (r_state == BUSY);
    assign io_bus.rtc_w_r    = r_wr;
    assign io_bus.rtc_addr   = r_addr;
    assign io_bus.rtc_wdata  = r_wdata;
    assign io_bus.rd_data    = r_rd_data;
endmodule
